nn_layer_sequencer: RTL and testbench

Sequences one inference of the two-layer digit-detection network: it enables the hidden-layer MAC array for one input pixel per accepted cycle, then the output-layer MAC array for one hidden activation per cycle. It emits the input index, accumulator-clear pulses and result-latch pulses around each layer. The block sits between the pixel source and the layer datapaths and replaces free-running enable generation with a start/busy/done handshake and pixel-stall support.

---
 rtl/nn_layer_sequencer_if.sv | 27 ++
 rtl/nn_layer_sequencer.sv | 85 ++++++++
 tb/tb_nn_layer_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Control bundle between the layer sequencer and the pixel source / layer datapaths.
interface nn_layer_sequencer_if #(
  parameter int IDX_W = 10
);
  logic             start;
  logic             pix_valid;
  logic             layer0_en;
  logic             layer1_en;
  logic [IDX_W-1:0] in_idx;
  logic             acc_clr;
  logic             act_latch;
  logic             out_latch;
  logic             busy;
  logic             done;

  // Sequencer side
  modport master (
    input  start, pix_valid,
    output layer0_en, layer1_en, in_idx, acc_clr, act_latch, out_latch, busy, done
  );

  // Pixel source / datapath side
  modport slave (
    output start, pix_valid,
    input  layer0_en, layer1_en, in_idx, acc_clr, act_latch, out_latch, busy, done
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences one inference of the two-layer network: clear, run and latch layer 0
// (stallable by pix_valid), then clear, run and latch layer 1, then pulse done.
module nn_layer_sequencer #(
  parameter int N_IN  = 784,
  parameter int N_HID = 64,
  parameter int IDX_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  nn_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, L0_CLR, L0_RUN, L0_LATCH, L1_CLR, L1_RUN, L1_LATCH, DONE
  } state_t;

  localparam logic [IDX_W-1:0] L0_LAST = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] L1_LAST = IDX_W'(N_HID - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  // State and index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state; idx is zero outside the run states so every CLR sees index 0
  always_comb begin
    state_nxt = state;
    idx_nxt   = '0;
    case (state)
      IDLE:     if (bus.start) state_nxt = L0_CLR;
      L0_CLR:   state_nxt = L0_RUN;
      L0_RUN: begin
        idx_nxt = idx;
        if (bus.pix_valid) begin
          if (idx == L0_LAST) begin
            state_nxt = L0_LATCH;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      L0_LATCH: state_nxt = L1_CLR;
      L1_CLR:   state_nxt = L1_RUN;
      L1_RUN: begin
        if (idx == L1_LAST) state_nxt = L1_LATCH;
        else                idx_nxt   = idx + IDX_W'(1);
      end
      L1_LATCH: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state; pix_valid is the only input feeding through
  always_comb begin
    bus.layer0_en = 1'b0;
    bus.layer1_en = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.act_latch = 1'b0;
    bus.out_latch = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE);
    bus.in_idx    = idx;
    case (state)
      L0_CLR, L1_CLR: bus.acc_clr   = 1'b1;
      L0_RUN:         bus.layer0_en = bus.pix_valid;
      L0_LATCH:       bus.act_latch = 1'b1;
      L1_RUN:         bus.layer1_en = 1'b1;
      L1_LATCH:       bus.out_latch = 1'b1;
      DONE:           bus.done      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: stimulus pushes expected output events (cycle, pulse, index),
// a negedge monitor pops and compares every cycle the DUT shows any pulse/enable.
module tb_nn_layer_sequencer;

  localparam int N_IN  = 784;
  localparam int N_HID = 64;
  localparam int PATN  = 2048;

  localparam logic [5:0] F_CLR  = 6'h01;
  localparam logic [5:0] F_L0   = 6'h02;
  localparam logic [5:0] F_L1   = 6'h04;
  localparam logic [5:0] F_ACT  = 6'h08;
  localparam logic [5:0] F_OUT  = 6'h10;
  localparam logic [5:0] F_DONE = 6'h20;

  typedef struct {
    int         cyc;
    logic [5:0] fl;
    int         idx;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.IDX_W(10)) bus0 ();
  nn_layer_sequencer_if #(.IDX_W(2))  bus1 ();

  nn_layer_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .IDX_W(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master));
  nn_layer_sequencer #(.N_IN(3), .N_HID(2), .IDX_W(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  cut = 32'h7fffffff;
  int  pv_base = 0;
  bit  pv_rand = 1'b0;
  bit  pat [PATN];
  int  l0_cnt [2];
  ev_t q0 [$];
  ev_t q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit pv_at(int t);
    int i = t - pv_base;
    if (!pv_rand) return 1'b1;
    if (i >= 0 && i < PATN) return pat[i];
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(int w, int t, logic [5:0] fl, int idx);
    ev_t e;
    if (t >= cut) return;
    e.cyc = t; e.fl = fl; e.idx = idx;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Expected event timeline for an inference whose start is sampled at edge s
  function automatic void gen(int w, int s, int nin, int nhid);
    int t = s + 1;
    int k = 0;
    push(w, t, F_CLR, 0); t++;
    while (k < nin) begin
      if (pv_at(t)) begin push(w, t, F_L0, k); k++; end
      t++;
    end
    push(w, t, F_ACT, 0); t++;
    push(w, t, F_CLR, 0); t++;
    for (int j = 0; j < nhid; j++) push(w, t + j, F_L1, j);
    t += nhid;
    push(w, t, F_OUT, 0);
    push(w, t + 1, F_DONE, 0);
  endfunction

  // Monitor: compare each observed event against the scoreboard head
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      logic [5:0] fl;
      int idx;
      logic bsy;
      ev_t e;
      if (w == 0) begin
        fl  = {bus0.done, bus0.out_latch, bus0.act_latch, bus0.layer1_en, bus0.layer0_en, bus0.acc_clr};
        idx = int'(bus0.in_idx); bsy = bus0.busy;
      end else begin
        fl  = {bus1.done, bus1.out_latch, bus1.act_latch, bus1.layer1_en, bus1.layer0_en, bus1.acc_clr};
        idx = int'(bus1.in_idx); bsy = bus1.busy;
      end
      if (fl != 6'h0) begin
        if (fl[1]) l0_cnt[w]++;
        checks++;
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
          errors++;
          $display("FAIL dut%0d unexpected event: cyc=%0d flags=%h idx=%0d, required none", w, cyc, fl, idx);
        end else begin
          e = (w == 0) ? q0.pop_front() : q1.pop_front();
          if (e.cyc != cyc || e.fl != fl || bsy !== 1'b1 ||
              ((fl & 6'h07) != 6'h0 && idx != e.idx)) begin
            errors++;
            $display("FAIL dut%0d event: got cyc=%0d flags=%h idx=%0d busy=%b, required cyc=%0d flags=%h idx=%0d busy=1",
                     w, cyc, fl, idx, bsy, e.cyc, e.fl, e.idx);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus0.pix_valid = pv_at(cyc);
    bus1.pix_valid = bus0.pix_valid;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic launch(bit both);
    bus0.start = 1'b1;
    if (both) bus1.start = 1'b1;
    pv_base = cyc + 2;
    gen(0, cyc, N_IN, N_HID);
    if (both) gen(1, cyc, 3, 2);
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic expect_idle(string nm);
    chk({nm, " outputs"}, int'({bus0.layer0_en, bus0.layer1_en, bus0.acc_clr, bus0.act_latch,
                              bus0.out_latch, bus0.busy, bus0.done}), 0);
    chk({nm, " in_idx"}, int'(bus0.in_idx), 0);
  endtask

  task automatic drain(string nm);
    chk({nm, " pending events"}, q0.size() + q1.size(), 0);
  endtask

  initial begin
    int s, z, k, c0;
    reset = 1'b1;
    bus0.start = 1'b0; bus1.start = 1'b0;
    bus0.pix_valid = 1'b1; bus1.pix_valid = 1'b1;
    ticks(3);
    expect_idle("reset");
    chk("reset small busy", int'(bus1.busy), 0);
    reset = 1'b0;
    ticks(2);

    // Nominal, both DUTs (small one: done at cycle 10)
    launch(1'b1);
    ticks(860);
    drain("nominal");

    // Random pixel stalls in layer 0
    for (int i = 0; i < PATN; i++) pat[i] = (i < 1800) ? 1'($urandom_range(0, 1)) : 1'b1;
    z = 0; k = 0;
    for (int i = 0; k < N_IN; i++) begin
      if (pat[i]) k++; else z++;
    end
    pv_rand = 1'b1;
    c0 = l0_cnt[0];
    launch(1'b0);
    ticks(853 + z + 5);
    drain("stall");
    chk("stall layer0_en count", l0_cnt[0] - c0, N_IN);
    pv_rand = 1'b0;
    ticks(2);

    // Starts in busy states are ignored; a start in the IDLE cycle restarts
    s = cyc;
    launch(1'b0);
    while (cyc < s + 10) tick();
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    while (cyc < s + 800) tick();
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    while (cyc < s + 853) tick();
    bus0.start = 1'b1; tick(); bus0.start = 1'b0;
    chk("idle after done busy", int'(bus0.busy), 0);
    launch(1'b0);
    ticks(860);
    drain("start ignored");

    // Reset in layer 0 and in layer 1
    s = cyc; cut = s + 401;
    launch(1'b0);
    while (cyc < s + 400) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    expect_idle("reset at 400");
    ticks(5);
    drain("reset at 400");
    s = cyc; cut = s + 821;
    launch(1'b0);
    while (cyc < s + 820) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    expect_idle("reset at 820");
    ticks(5);
    drain("reset at 820");
    cut = 32'h7fffffff;
    launch(1'b0);
    ticks(860);
    drain("after reset");

    // Back-to-back with start held high
    s = cyc;
    bus0.start = 1'b1;
    pv_base = s + 2;
    gen(0, s, N_IN, N_HID);
    gen(0, s + 854, N_IN, N_HID);
    while (cyc < s + 853) tick();
    chk("b2b done", int'(bus0.done), 1);
    chk("b2b busy at done", int'(bus0.busy), 1);
    tick();
    chk("b2b busy gap", int'(bus0.busy), 0);
    tick();
    chk("b2b busy restart", int'(bus0.busy), 1);
    while (cyc < s + 1000) tick();
    bus0.start = 1'b0;
    while (cyc < s + 1715) tick();
    drain("back-to-back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
